alu_control_mdu: RTL and testbench
==================================

Name: alu_control_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes ALUOp, Funct and Opcode into an extended ALU operation code, covering R-type, branch and immediate classes. It also sequences a multi-cycle multiply/divide unit (MDU), generating the start pulse and the HI/LO write strobe. It interlocks the pipeline when HI/LO is read or the MDU is reused while busy. It sits between the main control unit, the ALU and the MDU.

Parameters:
CTRL_W, 4, ALUControl width; must be >=4; codes are zero-extended when CTRL_W > 4.
MUL_LAT, 4, busy cycles for mult/multu; must be >=1.
DIV_LAT, 32, busy cycles for div/divu; must be >=1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
ALUOp  input  2  class: 00 add, 01 sub, 10 R-type (Funct), 11 immediate (Opcode)
Funct  input  6  instruction[5:0]
Opcode  input  6  instruction[31:26]
instr_valid  input  1  current instruction is real (not a bubble)
flush  input  1  abort any in-flight MDU operation
ALUControl  output  CTRL_W  ALU operation code
mdu_start  output  1  one-cycle start pulse to the MDU
mdu_op  output  2  00 mult, 01 multu, 10 div, 11 divu; held from start until done
mdu_busy  output  1  MDU operation in flight
hilo_we  output  1  one-cycle HI/LO write strobe
stall  output  1  freeze PC and instruction fetch this cycle

Behaviour:
- ALUControl is combinational.
  - Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0100, MUL 0101, SLT 0110, NOR 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1110.
- ALUOp decode:
  - ALUOp=00 -> ADD.
  - ALUOp=01 -> SUB.
  - ALUOp=10, by Funct: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 011100 MUL.
  - ALUOp=11, by Opcode: 001000/001001 ADD, 001010 SLT, 001011 SLTU, 001100 AND, 001101 OR, 001110 XOR.
  - Any unlisted combination -> ADD.
- MDU instructions: ALUOp=10 with Funct 011000 mult, 011001 multu, 011010 div, 011011 divu.
- HI/LO reads: ALUOp=10 with Funct 010000 mfhi, 010010 mflo.
- FSM states: IDLE, BUSY.
- Counter width: clog2(max(MUL_LAT, DIV_LAT)). The counter is internal.
- Accept condition (cycle t): IDLE and instr_valid and MDU instruction and !flush.
  - Edge after t: state=BUSY, cnt=LAT-1 (LAT chosen by op), mdu_op latched.
  - mdu_start=1 for cycle t+1 only.
- BUSY:
  - mdu_busy=1.
  - cnt decrements each cycle.
  - When cnt==0: hilo_we=1 that cycle, next state IDLE.
  - Busy spans cycles t+1 .. t+LAT; hilo_we is asserted in cycle t+LAT.
- Stall: stall = instr_valid & BUSY & (mfhi | mflo | MDU instruction). Stall is combinational.
  - Stall also holds in the last busy cycle, so the read or reissue proceeds in cycle t+LAT+1.
  - A reissued MDU op is accepted in the first IDLE cycle; no idle gap is required.
- flush:
  - In BUSY: next state IDLE; hilo_we is forced 0 in the flush cycle and never asserted for the aborted op; mdu_start is forced 0.
  - In IDLE with an accept-eligible instruction: the op is not accepted.
- instr_valid=0: no accept, stall=0. ALUControl is still decoded.
- Reset values: state IDLE, cnt 0, mdu_op 00, mdu_start 0, mdu_busy 0, hilo_we 0, stall 0.
  - Reset mid-operation aborts with no hilo_we.
  - ALUControl is driven purely by its inputs.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code localparams (ALU_ADD ... ALU_SLTU).
  - Funct and Opcode constants.
  - MDU op encodings.
  - FSM state typedef.
- One sub-module, alu_decode: the combinational ALUOp/Funct/Opcode -> ALUControl decoder.
- The top level holds the MDU FSM, counter and stall logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles while a mult is presented -> mdu_start, mdu_busy, hilo_we and stall are all 0; mdu_op=00.
- Decode sweep: every listed ALUOp/Funct/Opcode combination -> its exact code; ALUOp=10 with Funct 111111 -> 0010; ALUOp=11 with Opcode 001101 -> 0001.
- mult (011000), MUL_LAT=4, accepted in cycle 0 -> mdu_start=1 in cycle 1; mdu_busy=1 in cycles 1-4; hilo_we=1 in cycle 4 only; mdu_op=00 held.
- divu, DIV_LAT=32, then mflo presented from cycle 2 -> stall=1 in cycles 2-32; stall=0 in cycle 33; hilo_we=1 in cycle 32.
- Back-to-back: mult, then multu presented in cycle 1 -> stall=1 in cycles 1-4; multu accepted in cycle 5; mdu_start=1 in cycle 6 with mdu_op=01.
- flush in cycle 2 of a mult; separately, rst_n=0 in cycle 3 of a div -> IDLE next cycle, hilo_we never asserted, mdu_busy=0, stall=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and the MDU sequencer.
package alu_ctrl_pkg;

  // ALU operation codes (4-bit base encoding, zero-extended at the top)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  // ALUOp classes from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // R-type Funct field values
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MUL   = 6'b011100;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Immediate-class Opcode values
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  // MDU operation encodings; equal to Funct[1:0] of the MDU instructions
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // mult/multu/div/divu occupy Funct 0110xx
  function automatic logic is_mdu_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/Funct/Opcode to ALU operation code decoder.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic [5:0]        Opcode,
  output logic [CTRL_W-1:0] ALUControl
);

  logic [3:0] code;

  // Class decode; anything unlisted falls back to ADD
  always_comb begin
    code = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_RTYPE: begin
        case (Funct)
          FN_ADD, FN_ADDU: code = ALU_ADD;
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:          code = ALU_AND;
          FN_OR:           code = ALU_OR;
          FN_XOR:          code = ALU_XOR;
          FN_NOR:          code = ALU_NOR;
          FN_SLT:          code = ALU_SLT;
          FN_SLTU:         code = ALU_SLTU;
          FN_SLL:          code = ALU_SLL;
          FN_SRL:          code = ALU_SRL;
          FN_SRA:          code = ALU_SRA;
          FN_MUL:          code = ALU_MUL;
          default:         code = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        case (Opcode)
          OP_ADDI, OP_ADDIU: code = ALU_ADD;
          OP_SLTI:           code = ALU_SLT;
          OP_SLTIU:          code = ALU_SLTU;
          OP_ANDI:           code = ALU_AND;
          OP_ORI:            code = ALU_OR;
          OP_XORI:           code = ALU_XOR;
          default:           code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign ALUControl = CTRL_W'(code);

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus multi-cycle MDU sequencing and HI/LO interlock.
//   state | meaning
//   IDLE  | no MDU op in flight; an MDU instruction may be accepted
//   BUSY  | MDU op in flight; cnt counts down to the HI/LO write cycle
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic [5:0]        Opcode,
  input  logic              instr_valid,
  input  logic              flush,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              mdu_start,
  output logic [1:0]        mdu_op,
  output logic              mdu_busy,
  output logic              hilo_we,
  output logic              stall
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             start_q;

  logic is_mdu;
  logic is_read;
  logic accept;
  logic busy;

  alu_decode #(.CTRL_W(CTRL_W)) u_decode (
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .Opcode     (Opcode),
    .ALUControl (ALUControl)
  );

  assign is_mdu  = (ALUOp == ALUOP_RTYPE) && is_mdu_funct(Funct);
  assign is_read = (ALUOp == ALUOP_RTYPE) && ((Funct == FN_MFHI) || (Funct == FN_MFLO));
  assign busy    = (state == BUSY);
  assign accept  = !busy && instr_valid && is_mdu && !flush;

  // MDU sequencer: accept, count down the latency, return to IDLE on done or flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= MDU_MULT;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            op_q    <= Funct[1:0];
            cnt     <= Funct[1] ? DIV_CNT : MUL_CNT;
            start_q <= 1'b1;
          end
        end
        BUSY: begin
          if (flush || (cnt == '0)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are held at their reset values while rst_n is low; flush kills start and write-back
  assign mdu_busy  = rst_n && busy;
  assign mdu_op    = rst_n ? op_q : MDU_MULT;
  assign mdu_start = rst_n && start_q && !flush;
  assign hilo_we   = rst_n && busy && (cnt == '0) && !flush;
  assign stall     = rst_n && instr_valid && busy && (is_read || is_mdu);

endmodule

// File: tb/tb_alu_control_mdu.sv
module tb_alu_control_mdu;
  import alu_ctrl_pkg::*;

  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        aluop = 2'b00;
  logic [5:0]        funct = 6'b0;
  logic [5:0]        opcode = 6'b0;
  logic              instr_valid = 1'b0;
  logic              flush = 1'b0;
  logic [CTRL_W-1:0] alu_control;
  logic              mdu_start;
  logic [1:0]        mdu_op;
  logic              mdu_busy;
  logic              hilo_we;
  logic              stall;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model state: cycles of busy remaining, latched op, pending start pulse
  int         m_left = 0;
  logic [1:0] m_op = 2'b00;
  bit         m_start = 1'b0;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [5:0] opcode;
    logic [3:0] exp;
  } dec_vec_t;

  dec_vec_t vecs[$];

  logic [5:0] fpool [10] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI,
                             FN_MFLO, FN_ADD, FN_SLT, FN_MUL, FN_SRA};

  always #5 clk = ~clk;

  alu_control_mdu #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ALUOp       (aluop),
    .Funct       (funct),
    .Opcode      (opcode),
    .instr_valid (instr_valid),
    .flush       (flush),
    .ALUControl  (alu_control),
    .mdu_start   (mdu_start),
    .mdu_op      (mdu_op),
    .mdu_busy    (mdu_busy),
    .hilo_we     (hilo_we),
    .stall       (stall)
  );

  function automatic dec_vec_t mk(input logic [1:0] a, input logic [5:0] f,
                                  input logic [5:0] o, input logic [3:0] e);
    dec_vec_t v;
    v.aluop = a; v.funct = f; v.opcode = o; v.exp = e;
    return v;
  endfunction

  // listed combinations are looked up in the vector table; everything else is ADD
  function automatic logic [3:0] ref_dec(input logic [1:0] a, input logic [5:0] f,
                                         input logic [5:0] o);
    if (a == 2'b00) return 4'b0010;
    if (a == 2'b01) return 4'b0100;
    foreach (vecs[i]) begin
      if (vecs[i].aluop == a) begin
        if (a == 2'b10 && vecs[i].funct == f) return vecs[i].exp;
        if (a == 2'b11 && vecs[i].opcode == o) return vecs[i].exp;
      end
    end
    return 4'b0010;
  endfunction

  function automatic int mdu_index(input logic [1:0] a, input logic [5:0] f);
    logic [5:0] fns [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};
    if (a != 2'b10) return -1;
    for (int i = 0; i < 4; i++) if (fns[i] == f) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // apply one cycle of inputs and compare every output with the model
  task automatic drive(input logic r, input logic v, input logic fl,
                       input logic [1:0] a, input logic [5:0] f, input logic [5:0] o);
    int  idx;
    bit  rd;
    rst_n = r; instr_valid = v; flush = fl; aluop = a; funct = f; opcode = o;
    #3;
    idx = mdu_index(a, f);
    rd  = (a == 2'b10) && (f == 6'b010000 || f == 6'b010010);
    chk("alu_control", int'(alu_control), int'(ref_dec(a, f, o)));
    chk("mdu_busy", int'(mdu_busy), int'(r && m_left > 0));
    chk("hilo_we", int'(hilo_we), int'(r && m_left == 1 && !fl));
    chk("mdu_start", int'(mdu_start), int'(r && m_start && !fl));
    chk("stall", int'(stall), int'(r && v && m_left > 0 && (rd || idx >= 0)));
    chk("mdu_op", int'(mdu_op), r ? int'(m_op) : 0);
  endtask

  // advance the model across the clock edge, then the clock itself
  task automatic adv();
    int idx;
    idx = mdu_index(aluop, funct);
    if (!rst_n) begin
      m_left = 0; m_op = 2'b00; m_start = 1'b0;
    end else if (m_left > 0) begin
      m_left  = flush ? 0 : m_left - 1;
      m_start = 1'b0;
    end else if (instr_valid && idx >= 0 && !flush) begin
      m_left  = (idx >= 2) ? DIV_LAT : MUL_LAT;
      m_op    = 2'(idx);
      m_start = 1'b1;
    end else begin
      m_start = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bubble();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 6'b0, 6'b0);
  endtask

  initial begin
    logic [1:0] ra;
    logic [5:0] rf;
    logic [5:0] ro;

    vecs.push_back(mk(2'b00, 6'b100100, 6'b001101, 4'b0010));
    vecs.push_back(mk(2'b01, 6'b100100, 6'b001100, 4'b0100));
    vecs.push_back(mk(2'b10, 6'b100000, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b10, 6'b100001, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b10, 6'b100010, 6'b000000, 4'b0100));
    vecs.push_back(mk(2'b10, 6'b100011, 6'b000000, 4'b0100));
    vecs.push_back(mk(2'b10, 6'b100100, 6'b000000, 4'b0000));
    vecs.push_back(mk(2'b10, 6'b100101, 6'b000000, 4'b0001));
    vecs.push_back(mk(2'b10, 6'b100110, 6'b000000, 4'b0011));
    vecs.push_back(mk(2'b10, 6'b100111, 6'b000000, 4'b0111));
    vecs.push_back(mk(2'b10, 6'b101010, 6'b000000, 4'b0110));
    vecs.push_back(mk(2'b10, 6'b101011, 6'b000000, 4'b1110));
    vecs.push_back(mk(2'b10, 6'b000000, 6'b000000, 4'b1000));
    vecs.push_back(mk(2'b10, 6'b000010, 6'b000000, 4'b1001));
    vecs.push_back(mk(2'b10, 6'b000011, 6'b000000, 4'b1010));
    vecs.push_back(mk(2'b10, 6'b011100, 6'b000000, 4'b0101));
    vecs.push_back(mk(2'b10, 6'b111111, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b10, 6'b011000, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b10, 6'b010000, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001000, 4'b0010));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001001, 4'b0010));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001010, 4'b0110));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001011, 4'b1110));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001100, 4'b0000));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001101, 4'b0001));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b001110, 4'b0011));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b000000, 4'b0010));
    vecs.push_back(mk(2'b11, 6'b000000, 6'b111111, 4'b0010));

    // reset held for two cycles while a mult is presented
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 2'b10, 6'b011000, 6'b0);
      chk("rst_start", int'(mdu_start), 0);
      chk("rst_busy", int'(mdu_busy), 0);
      chk("rst_hilo", int'(hilo_we), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_op", int'(mdu_op), 0);
      adv();
    end

    // decode sweep, instr_valid low so the MDU stays idle
    foreach (vecs[i]) begin
      drive(1'b1, 1'b0, 1'b0, vecs[i].aluop, vecs[i].funct, vecs[i].opcode);
      chk("decode_vec", int'(alu_control), int'(vecs[i].exp));
      adv();
    end

    // mult accepted in cycle 0
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011000, 6'b0);
      else bubble();
      chk("mult_start", int'(mdu_start), int'(c == 1));
      chk("mult_busy", int'(mdu_busy), int'(c >= 1 && c <= 4));
      chk("mult_hilo", int'(hilo_we), int'(c == 4));
      if (c >= 1 && c <= 4) chk("mult_op", int'(mdu_op), 0);
      adv();
    end

    // divu then mflo from cycle 2
    for (int c = 0; c <= 34; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011011, 6'b0);
      else if (c >= 2 && c <= 33) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b010010, 6'b0);
      else bubble();
      chk("divu_stall", int'(stall), int'(c >= 2 && c <= 32));
      chk("divu_hilo", int'(hilo_we), int'(c == 32));
      if (c >= 1 && c <= 32) chk("divu_op", int'(mdu_op), 3);
      adv();
    end

    // mult then multu held from cycle 1 until it is accepted
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011000, 6'b0);
      else if (c <= 5) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011001, 6'b0);
      else bubble();
      chk("b2b_stall", int'(stall), int'(c >= 1 && c <= 4));
      chk("b2b_start", int'(mdu_start), int'(c == 1 || c == 6));
      chk("b2b_busy", int'(mdu_busy), int'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
      chk("b2b_hilo", int'(hilo_we), int'(c == 4 || c == 9));
      if (c == 6) chk("b2b_op", int'(mdu_op), 1);
      adv();
    end

    // flush in cycle 2 of a mult; flushed mult in idle cycle 5 is not accepted
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011000, 6'b0);
      else if (c == 2) drive(1'b1, 1'b0, 1'b1, 2'b00, 6'b0, 6'b0);
      else if (c == 5) drive(1'b1, 1'b1, 1'b1, 2'b10, 6'b011000, 6'b0);
      else bubble();
      chk("flush_busy", int'(mdu_busy), int'(c >= 1 && c <= 2));
      chk("flush_hilo", int'(hilo_we), 0);
      chk("flush_start", int'(mdu_start), int'(c == 1));
      adv();
    end

    // reset in cycle 3 of a div, mflo presented afterwards
    for (int c = 0; c <= 40; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b011010, 6'b0);
      else if (c == 3) drive(1'b0, 1'b1, 1'b0, 2'b10, 6'b010010, 6'b0);
      else if (c == 4) drive(1'b1, 1'b1, 1'b0, 2'b10, 6'b010010, 6'b0);
      else bubble();
      chk("rstdiv_hilo", int'(hilo_we), 0);
      chk("rstdiv_busy", int'(mdu_busy), int'(c >= 1 && c <= 2));
      if (c >= 3) chk("rstdiv_stall", int'(stall), 0);
      adv();
    end

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      ra = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
      rf = ($urandom_range(0, 1) == 1) ? fpool[$urandom_range(0, 9)] : 6'($urandom);
      ro = 6'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 49) == 0), ra, rf, ro);
      adv();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
